// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, bubble word, reset PC.
// Imported by the fetch interface, top level and PC register.
package fetch_pkg;

  localparam int                 INSTR_W          = 32;
  localparam logic [31:0]        DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] BUBBLE_INSTR     = '0;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // Fetch addresses are word aligned; the low two bits are always cleared.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant/response channel between fetch and imem.
// Address is held stable while imem_req is high; responses return in order.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter with reset > redirect > advance priority; exposes pc and pc+4.
// Updates on the clock edge; the caller decides when to advance or redirect.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  assign pc        = pc_q;
  assign pc_plus_4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (advance) begin
      pc_d = pc_plus_4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding imem request, PC+4/instruction to IF/ID; 2 cycles/instr at zero wait.
// stall freezes outputs (parks in HOLD after a capture); option FETCH_ALIGN_CHECK_EN flags misaligned redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  fetch_unit_if.master       imem,
  output logic [31:0]        PC_plus_4_out,
  output logic [INSTR_W-1:0] Instruction_out,
  output logic               fetch_valid,
  output logic               fetch_fault
);

  fetch_state_e       state_q, state_d;
  logic               discard_q, discard_d;
  logic [31:0]        pc4_q, pc4_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               capture;
  logic [31:0]        pc;
  logic [31:0]        pc_plus_4;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (align_pc(redirect_pc)),
    .advance     (capture),
    .pc          (pc),
    .pc_plus_4   (pc_plus_4)
  );

  assign imem.imem_req  = (state_q == REQ) && !reset;
  assign imem.imem_addr = pc;

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    capture   = 1'b0;
    case (state_q)
      REQ: begin
        // A grant coincident with a redirect belongs to the old path: its data must be dropped.
        if (imem.imem_gnt) begin
          state_d   = WAIT;
          discard_d = redirect;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          discard_d = 1'b0;
          state_d   = REQ;
          if (!discard_q && !redirect) begin
            capture = 1'b1;
            state_d = stall ? HOLD : REQ;
          end
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || !stall) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d   = REQ;
        discard_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc4_d   = pc4_q;
    instr_d = BUBBLE_INSTR;
    valid_d = 1'b0;
    if (!redirect) begin
      if (capture) begin
        pc4_d   = pc_plus_4;
        instr_d = imem.imem_rdata;
        valid_d = 1'b1;
      end else if (stall) begin
        instr_d = instr_q;
        valid_d = valid_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= REQ;
      discard_q <= 1'b0;
      pc4_q     <= 32'h0;
      instr_q   <= BUBBLE_INSTR;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      pc4_q     <= pc4_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
    end
  end

  assign PC_plus_4_out   = pc4_q;
  assign Instruction_out = instr_q;
  assign fetch_valid     = valid_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scripted memory responder, flag-based reference model, literal pins.
module tb_fetch_unit;
  import fetch_pkg::*;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc4_out;
  logic [31:0] instr_out;
  logic        fetch_valid;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem            (imem),
    .PC_plus_4_out   (pc4_out),
    .Instruction_out (instr_out),
    .fetch_valid     (fetch_valid),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 + (a << 8);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (fetch_valid === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: fetch_valid not seen within %0d cycles", name, budget);
    end
  endtask

  // Memory responder: grants after gnt_delay waiting cycles, answers rsp_lat cycles after grant.
  int          gnt_delay = 0;
  int          rsp_lat   = 1;
  int          req_age   = 0;
  int          mcyc      = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  bit          hs;
  logic [31:0] hs_addr;

  initial begin
    imem.imem_gnt    = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      hs      = (imem.imem_req === 1'b1) && (imem.imem_gnt === 1'b1);
      hs_addr = imem.imem_addr;
      if ((imem.imem_req === 1'b1) && !hs) req_age++;
      else req_age = 0;
      @(posedge clk);
      #2;
      mcyc++;
      if (hs) begin
        q_addr.push_back(hs_addr);
        q_due.push_back(mcyc - 1 + rsp_lat);
      end
      if (q_due.size() > 0 && q_due[0] <= mcyc) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = mem_word(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'hBAD0_BAD0;
      end
      imem.imem_gnt = (imem.imem_req === 1'b1) && (req_age >= gnt_delay);
    end
  end

  // Reference model: in-flight / stale / parked flags, checked every cycle after the first edge.
  logic [31:0] m_pc, m_pc4, m_instr;
  bit          m_busy, m_stale, m_held, m_valid, m_fault;

  initial begin
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0;
    m_busy = 0; m_stale = 0; m_held = 0; m_valid = 0; m_fault = 0;
    @(posedge clk);
    forever begin
      bit got;
      bit n_busy, n_stale, n_held;
      logic [31:0] n_pc;
      @(negedge clk);
      chk("model_req", {31'b0, imem.imem_req}, {31'b0, (!reset && !m_busy && !m_held)});
      chk("model_addr", imem.imem_addr, m_pc);
      chk("model_pc4", pc4_out, m_pc4);
      chk("model_instr", instr_out, m_instr);
      chk("model_valid", {31'b0, fetch_valid}, {31'b0, m_valid});
      chk("model_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
      if (reset) begin
        m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0;
        m_busy = 0; m_stale = 0; m_held = 0; m_valid = 0; m_fault = 0;
      end else begin
        n_busy = m_busy; n_stale = m_stale; n_held = m_held; n_pc = m_pc;
        got = 0;
        if (!m_busy && !m_held && imem.imem_gnt) begin
          n_busy  = 1;
          n_stale = redirect;
        end
        if (m_busy && imem.imem_rvalid) begin
          n_busy  = 0;
          n_stale = 0;
          got     = !m_stale && !redirect;
        end else if (m_busy && redirect) begin
          n_stale = 1;
        end
        if (m_held && (redirect || !stall)) n_held = 0;
        if (got) begin
          m_pc4   = m_pc + 32'd4;
          m_instr = imem.imem_rdata;
          m_valid = 1;
          n_pc    = m_pc + 32'd4;
          n_held  = stall;
        end else if (redirect || !stall) begin
          m_instr = 32'h0;
          m_valid = 0;
        end
        if (redirect) begin
          n_pc = {redirect_pc[31:2], 2'b00};
          if (ALIGN_CHK && redirect_pc[1:0] != 2'b00) m_fault = 1;
        end
        m_busy = n_busy; m_stale = n_stale; m_held = n_held; m_pc = n_pc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) adv();
    at_neg();
    chk("rst_req", {31'b0, imem.imem_req}, 32'd0);
    chk("rst_addr", imem.imem_addr, 32'h0);
    chk("rst_pc4", pc4_out, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

    // Zero-wait fetch of 0x0, then capture of 0x4 under stall.
    adv(); reset = 1'b0;
    at_neg();
    chk("first_req", {31'b0, imem.imem_req}, 32'd1);
    chk("first_addr", imem.imem_addr, 32'h0);
    wait_valid("first_fetch", 10);
    chk("first_pc4", pc4_out, 32'h4);
    chk("first_instr", instr_out, 32'h0050_0093);
    chk("second_addr", imem.imem_addr, 32'h4);
    adv(); stall = 1'b1;
    at_neg();
    chk("bubble_valid", {31'b0, fetch_valid}, 32'd0);
    chk("bubble_instr", instr_out, 32'h0);
    for (int i = 0; i < 3; i++) begin
      adv();
      at_neg();
      chk("stall_pc4", pc4_out, 32'h8);
      chk("stall_instr", instr_out, 32'h0050_0493);
      chk("stall_valid", {31'b0, fetch_valid}, 32'd1);
      chk("stall_req", {31'b0, imem.imem_req}, 32'd0);
    end
    adv(); stall = 1'b0; rsp_lat = 3;
    at_neg();
    chk("unstall_frozen", {31'b0, fetch_valid}, 32'd1);
    adv();
    at_neg();
    chk("unstall_bubble", {31'b0, fetch_valid}, 32'd0);
    chk("unstall_instr", instr_out, 32'h0);
    chk("unstall_pc4", pc4_out, 32'h8);
    chk("unstall_addr", imem.imem_addr, 32'h8);

    // Redirect while waiting for the 0x8 response.
    adv(); redirect = 1'b1; redirect_pc = 32'h100;
    at_neg();
    adv(); redirect = 1'b0; rsp_lat = 1;
    at_neg();
    chk("wait_req", {31'b0, imem.imem_req}, 32'd0);
    adv();
    at_neg();
    chk("dropped_valid", {31'b0, fetch_valid}, 32'd0);
    adv();
    at_neg();
    chk("redir_req", {31'b0, imem.imem_req}, 32'd1);
    chk("redir_addr", imem.imem_addr, 32'h100);

    // Capture 0x100 under stall, then redirect+stall together in HOLD.
    adv(); stall = 1'b1;
    at_neg();
    adv();
    at_neg();
    chk("hold_pc4", pc4_out, 32'h104);
    chk("hold_instr", instr_out, 32'h0051_0093);
    adv(); redirect = 1'b1; redirect_pc = 32'h200;
    at_neg();
    chk("hold_still_valid", {31'b0, fetch_valid}, 32'd1);
    adv(); redirect = 1'b0;
    at_neg();
    chk("hold_redir_valid", {31'b0, fetch_valid}, 32'd0);
    chk("hold_redir_instr", instr_out, 32'h0);
    chk("hold_redir_addr", imem.imem_addr, 32'h200);

    // Misaligned redirect coinciding with the 0x200 response.
    adv(); stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h102;
    at_neg();
    adv(); redirect = 1'b0; rsp_lat = 4;
    at_neg();
    chk("align_addr", imem.imem_addr, 32'h100);
    chk("align_fault", {31'b0, fetch_fault}, {31'b0, ALIGN_CHK});

    // Reset mid-transaction; the late response lands while requesting and is ignored.
    adv(); reset = 1'b1;
    at_neg();
    adv();
    at_neg();
    chk("rst2_fault", {31'b0, fetch_fault}, 32'd0);
    adv(); reset = 1'b0; gnt_delay = 3;
    at_neg();
    chk("gntdly_addr0", imem.imem_addr, 32'h0);
    adv(); rsp_lat = 1;
    at_neg();
    chk("gntdly_req1", {31'b0, imem.imem_req}, 32'd1);
    chk("gntdly_valid1", {31'b0, fetch_valid}, 32'd0);
    adv();
    at_neg();
    chk("gntdly_req2", {31'b0, imem.imem_req}, 32'd1);
    chk("gntdly_addr2", imem.imem_addr, 32'h0);
    wait_valid("gntdly_fetch", 10);
    chk("gntdly_pc4", pc4_out, 32'h4);
    chk("gntdly_instr", instr_out, 32'h0050_0093);

    // Wrap: fetch at 0xFFFF_FFFC yields PC+4 of zero.
    adv(); gnt_delay = 0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    at_neg();
    adv(); redirect = 1'b0;
    at_neg();
    wait_valid("wrap_fetch", 20);
    chk("wrap_pc4", pc4_out, 32'h0);
    chk("wrap_instr", instr_out, 32'h004F_FC93);
    chk("wrap_addr", imem.imem_addr, 32'h0);

    repeat (5) adv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that produces the PC+4 / instruction pair consumed by the IF/ID pipeline register. Owns the program counter, issues single-outstanding requests to instruction memory over a request/grant/response handshake, holds its outputs under hazard stall, and redirects on taken branches/jumps. Outputs connect directly to the IF/ID register inputs, which capture every cycle; an all-zero instruction is the pipeline bubble.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit: downstream not consuming, hold outputs
- redirect  in  1  taken branch/jump from later stage
- redirect_pc  in  32  target PC when redirect=1
- imem_req  out  1  request valid
- imem_addr  out  32  fetch address, stable while imem_req=1
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid (in-order, ≥1 cycle after grant)
- imem_rdata  in  32  instruction word
- PC_plus_4_out  out  32  fetched PC + 4, to IF/ID
- Instruction_out  out  32  fetched instruction or 32'h0 bubble, to IF/ID
- fetch_valid  out  1  Instruction_out holds a real instruction
- fetch_fault  out  1  misaligned redirect (only with FETCH_ALIGN_CHECK_EN)

## Operation
- States: REQ, WAIT, HOLD. Registers: pc, state, discard flag, output registers.
- REQ: imem_req=1, imem_addr=pc. imem_gnt=1 → WAIT. Request held until granted.
- WAIT: imem_req=0. On imem_rvalid: if discard=1, drop data, clear discard, → REQ (outputs bubble). Else Instruction_out←imem_rdata, PC_plus_4_out←pc+4, fetch_valid←1, pc←pc+4; → HOLD if stall=1, else → REQ.
- HOLD: outputs frozen while stall=1. stall=0 → REQ; at that edge outputs become bubble (fetch_valid=0, Instruction_out=0, PC_plus_4_out unchanged).
- In REQ/WAIT with no new capture, outputs are bubble each cycle unless stall=1 (stall freezes current outputs in any state).
- redirect (highest priority, any state): pc←redirect_pc; outputs→bubble at that edge regardless of stall; REQ→REQ (address changes next cycle, ungranted request abandoned; if imem_gnt=1 in same cycle, set discard, → WAIT); WAIT→set discard, stay WAIT (unless imem_rvalid same cycle: data dropped, → REQ, no discard); HOLD→REQ.
- Arithmetic: pc+4 modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000 silently.

## Timing
- Reset values: pc=RESET_PC, state=REQ, discard=0, imem_req=0, imem_addr=RESET_PC, PC_plus_4_out=0, Instruction_out=0, fetch_valid=0, fetch_fault=0.
- First cycle after reset deasserts: imem_req=1, imem_addr=RESET_PC.
- Zero-wait memory (gnt in REQ, rvalid next cycle): one instruction every 2 cycles; output visible cycle after rvalid.
- reset mid-transaction: all state to reset values; a response arriving after reset with no granted request is ignored (WAIT not active).
- imem_rvalid outside WAIT is ignored.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]≠0 sets fetch_fault=1 (sticky until reset), pc←{redirect_pc[31:2],2'b00}, else same redirect behaviour.
- Undefined: redirect_pc[1:0] ignored (pc bits [1:0] forced 0); fetch_fault tied 0.

## Structure
- Shared package/header fetch_pkg: state encoding (REQ/WAIT/HOLD), BUBBLE_INSTR=32'h0, default RESET_PC, INSTR_W=32.
- Sub-module pc_register: holds pc, applies reset/redirect/increment priority, exposes pc and pc+4.

## Test plan
- Reset then zero-wait memory returning 0x00500093 at 0x0 → imem_addr 0x0, then 0x4; PC_plus_4_out=0x4, Instruction_out=0x00500093, fetch_valid=1 one cycle, then bubble.
- gnt delayed 3 cycles → imem_req and imem_addr=0x0 held stable all 3 cycles, no output until rvalid.
- stall=1 for 4 cycles after capture → outputs frozen, imem_req=0; stall drops → bubble next cycle, request 0x8 issued.
- redirect to 0x100 while in WAIT, response for 0x8 arrives → response dropped, fetch_valid=0, next imem_addr=0x100.
- redirect and stall same cycle in HOLD → outputs bubble, next imem_addr=redirect_pc.
- With FETCH_ALIGN_CHECK_EN: redirect_pc=0x102 → fetch_fault=1, imem_addr=0x100; without: fetch_fault=0, imem_addr=0x100.
